// File: rtl/fade_pkg.sv
// ---------------------------------------------------------------------------
// fade_pkg
//   Shared definitions for the RGB fade datapath: hue sector encoding,
//   default timing constants and the duty-width helper used to size every
//   duty-carrying bus (duty registers, ramp, PWM compare counters).
// ---------------------------------------------------------------------------
package fade_pkg;

  // Hue sector. Each name lists the channel held at full scale, the channel
  // that is ramping and the ramp direction.
  typedef logic [2:0] sector_t;

  localparam sector_t SECT_R_G_UP = 3'd0; // R full, G rising
  localparam sector_t SECT_G_R_DN = 3'd1; // G full, R falling
  localparam sector_t SECT_G_B_UP = 3'd2; // G full, B rising
  localparam sector_t SECT_B_G_DN = 3'd3; // B full, G falling
  localparam sector_t SECT_B_R_UP = 3'd4; // B full, R rising
  localparam sector_t SECT_R_B_DN = 3'd5; // R full, B falling

  // Defaults give one full colour cycle per second at 12 MHz.
  localparam int PWM_INTERVAL_DEF    = 1200;
  localparam int UPDATE_INTERVAL_DEF = 10000;
  localparam int STEP_DEF            = 6;

  // Bits needed to hold a duty value in 0..interval inclusive.
  function automatic int duty_w(input int interval);
    return $clog2(interval + 1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//   Free-running prescaler that emits a one-cycle tick every INTERVAL enabled
//   clocks. Disabling holds the count where it is (no clear), so a paused
//   interval resumes and completes its remaining clocks once re-enabled.
//
// Ports
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (count returns to 0)
//   en    in   count enable
//   tick  out  high for the cycle in which the count sits at INTERVAL-1
//               while en is high; the count wraps to 0 on that edge
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter  int INTERVAL = 10000,
  localparam int CW       = (INTERVAL > 1) ? $clog2(INTERVAL) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hue_duty_gen.sv
// ---------------------------------------------------------------------------
// hue_duty_gen
//   Walks the hue wheel through six sectors, ramping one colour channel per
//   sector, and presents per-channel duty values to the downstream PWM stage.
//   Staged duties are a pure function of (sector, ramp); the outputs are a
//   second register bank that only reloads on frame_start, so a PWM frame
//   never sees a duty change part-way through.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   en           in   advance enable; low freezes prescaler, ramp and sector
//                     (output reloading on frame_start continues)
//   frame_start  in   one-cycle pulse at each PWM frame boundary
//   duty_r/g/b   out  latched duty values, 0..PWM_INTERVAL
//   sector       out  current (staged) hue sector, 0..5
// ---------------------------------------------------------------------------
module hue_duty_gen
  import fade_pkg::*;
#(
  parameter  int PWM_INTERVAL    = PWM_INTERVAL_DEF,
  parameter  int STEP            = STEP_DEF,
  parameter  int UPDATE_INTERVAL = UPDATE_INTERVAL_DEF,
  localparam int DW              = duty_w(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          frame_start,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic [2:0]    sector
);

  localparam logic [DW-1:0] FULL   = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] STEP_W = DW'(STEP);

  logic tick;

  logic [DW-1:0] ramp_q, ramp_d;
  sector_t       sector_q, sector_d;

  logic [DW-1:0] staged_r, staged_g, staged_b;
  logic [DW-1:0] ramp_dn;

  logic [DW-1:0] duty_r_q, duty_r_d;
  logic [DW-1:0] duty_g_q, duty_g_d;
  logic [DW-1:0] duty_b_q, duty_b_d;

  tick_gen #(
    .INTERVAL (UPDATE_INTERVAL)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // Ramp / sector advance. The ramp wraps one step before full scale, so it
  // never equals PWM_INTERVAL; the full-scale point of a rising channel is
  // supplied by the next sector holding that channel at FULL. Since
  // ramp <= FULL-STEP, ramp+STEP fits in DW bits.
  always_comb begin
    ramp_d   = ramp_q;
    sector_d = sector_q;
    if (tick) begin
      if ((ramp_q + STEP_W) == FULL) begin
        ramp_d   = '0;
        sector_d = (sector_q == SECT_R_B_DN) ? SECT_R_G_UP
                                             : sector_t'(sector_q + 3'd1);
      end else begin
        ramp_d = ramp_q + STEP_W;
      end
    end
  end

  // Staged duties. ramp < FULL, so the falling value cannot underflow.
  always_comb begin
    ramp_dn  = FULL - ramp_q;
    staged_r = '0;
    staged_g = '0;
    staged_b = '0;
    case (sector_q)
      SECT_R_G_UP: begin
        staged_r = FULL;
        staged_g = ramp_q;
      end
      SECT_G_R_DN: begin
        staged_r = ramp_dn;
        staged_g = FULL;
      end
      SECT_G_B_UP: begin
        staged_g = FULL;
        staged_b = ramp_q;
      end
      SECT_B_G_DN: begin
        staged_g = ramp_dn;
        staged_b = FULL;
      end
      SECT_B_R_UP: begin
        staged_r = ramp_q;
        staged_b = FULL;
      end
      SECT_R_B_DN: begin
        staged_r = FULL;
        staged_b = ramp_dn;
      end
      default: begin
        // Unreachable encodings 6..7 stage all channels dark.
      end
    endcase
  end

  // Output latch. It samples the staged values from the current (pre-tick)
  // ramp/sector, so a tick on the same edge only shows up at the next frame.
  always_comb begin
    duty_r_d = duty_r_q;
    duty_g_d = duty_g_q;
    duty_b_d = duty_b_q;
    if (frame_start) begin
      duty_r_d = staged_r;
      duty_g_d = staged_g;
      duty_b_d = staged_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_q   <= '0;
      sector_q <= SECT_R_G_UP;
      duty_r_q <= FULL;
      duty_g_q <= '0;
      duty_b_q <= '0;
    end else begin
      ramp_q   <= ramp_d;
      sector_q <= sector_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
    end
  end

  assign duty_r = duty_r_q;
  assign duty_g = duty_g_q;
  assign duty_b = duty_b_q;
  assign sector = sector_q;

endmodule

// File: tb/tb_hue_duty_gen.sv
// ---------------------------------------------------------------------------
// tb_hue_duty_gen
//   Directed bench for hue_duty_gen with PWM_INTERVAL=12, STEP=3,
//   UPDATE_INTERVAL=4. A tick-count model predicts the outputs every cycle;
//   literal expectations at chosen edges pin the model to hand-worked values.
// ---------------------------------------------------------------------------
module tb_hue_duty_gen;

  localparam int M   = 12;
  localparam int STP = 3;
  localparam int UI  = 4;
  localparam int SPS = M / STP;            // ticks per sector
  localparam int DW  = fade_pkg::duty_w(M);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic frame_start = 1'b1;

  logic [DW-1:0] duty_r, duty_g, duty_b;
  logic [2:0]    sector;

  always #5 clk = ~clk;

  hue_duty_gen #(
    .PWM_INTERVAL    (M),
    .STEP            (STP),
    .UPDATE_INTERVAL (UI)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .frame_start (frame_start),
    .duty_r      (duty_r),
    .duty_g      (duty_g),
    .duty_b      (duty_b),
    .sector      (sector)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State is just "how many ticks have happened" plus the prescaler phase;
  // sector and ramp follow arithmetically from the tick total.
  int m_pc    = 0;
  int m_ticks = 0;
  int m_r     = M;
  int m_g     = 0;
  int m_b     = 0;

  function automatic int sect_of(input int n);
    return (n / SPS) % 6;
  endfunction

  function automatic void staged(input int n, output int r, output int g, output int b);
    int s, up, dn;
    s  = sect_of(n);
    up = (n % SPS) * STP;
    dn = M - up;
    r = 0; g = 0; b = 0;
    case (s)
      0: begin r = M;  g = up; end
      1: begin r = dn; g = M;  end
      2: begin g = M;  b = up; end
      3: begin g = dn; b = M;  end
      4: begin r = up; b = M;  end
      default: begin r = M; b = dn; end
    endcase
  endfunction

  initial begin
    bit t;
    int r, g, b;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pc = 0; m_ticks = 0; m_r = M; m_g = 0; m_b = 0;
      end else begin
        t = en && (m_pc == UI - 1);
        if (frame_start) begin
          staged(m_ticks, r, g, b);
          m_r = r; m_g = g; m_b = b;
        end
        if (en) m_pc = (m_pc + 1) % UI;
        if (t) m_ticks++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("cyc_duty_r", duty_r, m_r);
      check("cyc_duty_g", duty_g, m_g);
      check("cyc_duty_b", duty_b, m_b);
      check("cyc_sector", sector, sect_of(m_ticks));
    end
  end

  // ---------------- driver helpers ----------------
  int e = 0;   // rising edges since the last reset release

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic step_to(input int k);
    while (e < k) step();
  endtask

  task automatic check_out(input string name, input int r, input int g, input int b);
    check({name, "_r"}, duty_r, r);
    check({name, "_g"}, duty_g, g);
    check({name, "_b"}, duty_b, b);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int sect_seq[$];
    logic [2:0] last_sect;

    repeat (3) @(negedge clk);
    check_out("por", M, 0, 0);
    check("por_sector", sector, 0);

    // Release with en and frame_start high.
    @(negedge clk);
    rst = 1'b0; en = 1'b1; frame_start = 1'b1; e = 0;

    // First ramp step and full wheel (24 ticks = 96 clocks).
    last_sect = 3'd0;
    sect_seq.push_back(0);
    for (int k = 1; k <= 97; k++) begin
      step();
      if (sector !== last_sect) begin
        sect_seq.push_back(int'(sector));
        last_sect = sector;
      end
      if (k == 4) begin
        check_out("first4", M, 0, 0);
        check("first4_sector", sector, 0);
      end
      if (k == 5)  check_out("first_step", M, 3, 0);
      if (k == 16) check("sect1_sector", sector, 1);
      if (k == 17) check_out("sect1", M, M, 0);
      if (k == 40) check_out("sect2_mid", 0, M, 3);
      if (k == 96) check("wheel_sector", sector, 0);
      if (k == 97) check_out("wheel", M, 0, 0);
    end
    check("wheel_nsect", sect_seq.size(), 7);
    for (int i = 0; i < 7 && i < sect_seq.size(); i++)
      check("wheel_seq", sect_seq[i], i % 6);

    // Frame gating: 40 clocks without frame_start.
    @(negedge clk);
    frame_start = 1'b0;
    step_to(137);
    check_out("gated_hold", M, 0, 0);
    check("gated_sector", sector, 2);
    @(negedge clk);
    frame_start = 1'b1;
    step();
    check_out("gated_load", 0, M, 6);
    @(negedge clk);
    frame_start = 1'b0;

    // Collision: frame_start on the tick edge that moves ramp 3 -> 6.
    step_to(151);
    @(negedge clk);
    frame_start = 1'b1;
    step();
    check_out("collide", 0, 9, M);
    check("collide_sector", sector, 3);
    @(negedge clk);
    frame_start = 1'b0;
    step();
    @(negedge clk);
    frame_start = 1'b1;
    step();
    check_out("collide_next", 0, 6, M);

    // Enable hold at prescaler count 2 for 10 clocks.
    @(negedge clk);
    en = 1'b0;
    step_to(164);
    check_out("hold", 0, 6, M);
    check("hold_sector", sector, 3);
    @(negedge clk);
    en = 1'b1;
    step();
    check_out("resume1", 0, 6, M);
    step();
    check_out("resume2", 0, 6, M);
    step();
    check_out("resume_tick", 0, 3, M);

    // Reset mid-run: immediate return to reset values.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_out("midrst", M, 0, 0);
    check("midrst_sector", sector, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; en = 1'b1; frame_start = 1'b1; e = 0;
    step_to(4);
    check_out("post_rst4", M, 0, 0);
    check("post_rst4_sector", sector, 0);
    step();
    check_out("post_rst5", M, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
